// File: rtl/camera_capture_pkg.sv
// Shared definitions for the camera capture path: command codes, capture states and defaults.
package camera_capture_pkg;

    localparam logic [31:0] CMD_START = 32'h0000_0001;
    localparam logic [31:0] CMD_STOP  = 32'h0000_0002;

    localparam int BURST_LEN_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FLUSH   = 2'd3
    } cap_state_t;

endpackage

// File: rtl/camera_capture_deserializer.sv
// Packs narrow input beats into one wide word, lowest beat in the lowest bits.
// A flush emits a partially filled word with the unused upper beats zeroed.
module camera_capture_deserializer #(
    parameter int INLOGBITS  = 3,
    parameter int OUTLOGBITS = 6,
    localparam int IN_W      = 2 ** INLOGBITS,
    localparam int OUT_W     = 2 ** OUTLOGBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             flush,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
);

    localparam int RATIO_LOG = OUTLOGBITS - INLOGBITS;

    logic [RATIO_LOG-1:0] idx;
    logic [OUT_W-1:0]     acc;

    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; a blocking write would leak into later lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                if (idx != '0) begin
                    out_data  <= acc;
                    out_valid <= 1'b1;
                end
                idx <= '0;
                acc <= '0;
            end else if (in_valid) begin
                if (&idx) begin
                    out_data  <= {in_data, acc[OUT_W-IN_W-1:0]};
                    out_valid <= 1'b1;
                    acc       <= '0;
                    idx       <= '0;
                end else begin
                    acc[idx*IN_W +: IN_W] <= in_data;
                    idx                   <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/camera_capture.sv
// Camera capture: packs 8-bit pixels into 64-bit words, buffers them in a FIFO and
// offers them to the AXI burst writer; started and stopped over the command channel.
module camera_capture
    import camera_capture_pkg::*;
#(
    parameter int BURST_LEN    = BURST_LEN_DEF,
    parameter int FIFO_LOG     = 6,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic [31:0] cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic        cam_pix_valid,
    input  logic [7:0]  cam_data,
    output logic [63:0] wdata,
    output logic        wdata_valid,
    input  logic        wdata_ready,
    output logic        wdata_burst_valid,
    output logic        frame_done,
    output logic        overflow_err,
    output logic [7:0]  debug
);

    localparam int DEPTH = 2 ** FIFO_LOG;

    cap_state_t          state;
    logic                vsync_q;
    logic                stop_pending;
    logic                eof_d1;
    logic [18:0]         pix_cnt;
    logic                is_start, is_stop;
    logic                vsync_fall, vsync_rise, frame_end, pix_accept;
    logic                pk_valid;
    logic [63:0]         pk_data;
    logic [63:0]         mem [DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr, rd_ptr;
    logic [FIFO_LOG:0]   count;
    logic                fifo_full, do_push, do_pop;

    assign cmd_ready  = 1'b1;
    assign is_start   = cmd_valid && (cmd == CMD_START);
    assign is_stop    = cmd_valid && (cmd == CMD_STOP);
    assign vsync_fall = vsync_q && !cam_vsync;
    assign vsync_rise = !vsync_q && cam_vsync;
    assign frame_end  = vsync_rise || (pix_cnt == 19'(FRAME_PIXELS));
    // A full frame accepts no further pixels while it waits to be flushed.
    assign pix_accept = (state == ST_CAPTURE) && cam_href && cam_pix_valid && !cam_vsync
                        && (pix_cnt != 19'(FRAME_PIXELS));

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            vsync_q      <= 1'b0;
            stop_pending <= 1'b0;
            eof_d1       <= 1'b0;
            frame_done   <= 1'b0;
            pix_cnt      <= '0;
        end else begin
            vsync_q    <= cam_vsync;
            eof_d1     <= (state == ST_FLUSH);
            frame_done <= eof_d1;
            if (pix_accept) pix_cnt <= pix_cnt + 1'b1;
            unique case (state)
                ST_IDLE: begin
                    stop_pending <= 1'b0;
                    if (is_start) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (is_stop) begin
                        state <= ST_IDLE;
                    end else if (vsync_fall) begin
                        state   <= ST_CAPTURE;
                        pix_cnt <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (is_stop)   stop_pending <= 1'b1;
                    if (frame_end) state        <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    state        <= (stop_pending || is_stop) ? ST_IDLE : ST_ARMED;
                    stop_pending <= 1'b0;
                end
            endcase
        end
    end

    camera_capture_deserializer #(.INLOGBITS(3), .OUTLOGBITS(6)) u_deser (
        .clk       (fclk),
        .rst_n     (rst_n),
        .in_valid  (pix_accept),
        .in_data   (cam_data),
        .flush     (state == ST_FLUSH),
        .out_valid (pk_valid),
        .out_data  (pk_data)
    );

    // Fullness is judged on the pre-pop count, so a push into a full FIFO drops
    // even when the writer pops in the same cycle.
    assign fifo_full = (count == (FIFO_LOG+1)'(DEPTH));
    assign do_push   = pk_valid && !fifo_full;
    assign do_pop    = wdata_ready && (count != '0);

    // NOTE: the storage array has no reset; emptiness is tracked by the pointers
    // and count, and the read port is masked while the FIFO is empty.
    always_ff @(posedge fclk) begin
        if (do_push) mem[wr_ptr] <= pk_data;
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (pk_valid && fifo_full) overflow_err <= 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign wdata_valid       = (count != '0);
    assign wdata             = wdata_valid ? mem[rd_ptr] : '0;
    assign wdata_burst_valid = (count >= (FIFO_LOG+1)'(BURST_LEN))
                               || ((state != ST_CAPTURE) && wdata_valid);
    assign debug             = {2'b00, state, stop_pending, fifo_full, overflow_err, frame_done};

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with a scoreboard of expected packed words.
module tb_camera_capture;
    import camera_capture_pkg::*;

    localparam int FP = 1024;

    logic        fclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cmd = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cam_vsync = 1'b1;
    logic        cam_href = 1'b0;
    logic        cam_pix_valid = 1'b0;
    logic [7:0]  cam_data = '0;
    logic [63:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready = 1'b0;
    logic        wdata_burst_valid;
    logic        frame_done;
    logic        overflow_err;
    logic [7:0]  debug;

    always #5 fclk = ~fclk;

    camera_capture #(.BURST_LEN(16), .FIFO_LOG(6), .FRAME_PIXELS(FP)) dut (
        .fclk              (fclk),
        .rst_n             (rst_n),
        .cmd               (cmd),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cam_vsync         (cam_vsync),
        .cam_href          (cam_href),
        .cam_pix_valid     (cam_pix_valid),
        .cam_data          (cam_data),
        .wdata             (wdata),
        .wdata_valid       (wdata_valid),
        .wdata_ready       (wdata_ready),
        .wdata_burst_valid (wdata_burst_valid),
        .frame_done        (frame_done),
        .overflow_err      (overflow_err),
        .debug             (debug)
    );

    int          n_assert = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_word = '0;
    int          m_idx = 0;
    int          pushed = 0;
    int          push_limit = 1 << 30;
    int          words_seen = 0;
    int          fd_count = 0;
    logic [63:0] first_word = '0;
    logic [63:0] last_word = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: observe pops and frame_done mid-cycle, then step past the edge.
    task automatic cycle();
        logic [63:0] e;
        @(negedge fclk);
        if (frame_done === 1'b1) fd_count++;
        if (wdata_valid === 1'b1 && wdata_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pop_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("word", wdata, e);
            end
            if (words_seen == 0) first_word = wdata;
            last_word = wdata;
            words_seen++;
        end
        @(posedge fclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic model_word(input logic [63:0] w);
        if (pushed < push_limit) exp_q.push_back(w);
        pushed++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_word[m_idx*8 +: 8] = b;
        m_idx++;
        if (m_idx == 8) begin
            model_word(m_word);
            m_word = '0;
            m_idx  = 0;
        end
    endtask

    task automatic model_flush();
        if (m_idx != 0) model_word(m_word);
        m_word = '0;
        m_idx  = 0;
    endtask

    task automatic pixels(input int n, input int base, input bit accepted);
        for (int i = 0; i < n; i++) begin
            cam_href      = 1'b1;
            cam_pix_valid = 1'b1;
            cam_data      = 8'(base + i);
            if (accepted) model_byte(cam_data);
            cycle();
        end
        cam_href      = 1'b0;
        cam_pix_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        cmd       = '0;
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        cycle();
        cam_vsync = 1'b0;
        cycle();
    endtask

    task automatic frame_end_vsync();
        model_flush();
        cam_vsync = 1'b1;
        cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(wdata_valid), 64'd0);
        check({tag, "_wdata"}, wdata, 64'd0);
        check({tag, "_burst"}, 64'(wdata_burst_valid), 64'd0);
        check({tag, "_fdone"}, 64'(frame_done), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_err), 64'd0);
        check({tag, "_debug"}, 64'(debug), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        // Reset state
        idle(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cycle();

        // Full ramp frame with the writer always ready
        wdata_ready = 1'b1;
        send_cmd(CMD_START);
        check("t1_armed", 64'(debug[5:4]), 64'(ST_ARMED));
        frame_start();
        check("t1_capture", 64'(debug[5:4]), 64'(ST_CAPTURE));
        words_seen = 0;
        fd_count   = 0;
        pixels(FP, 0, 1'b1);
        idle(10);
        check("t1_words", 64'(words_seen), 64'(FP / 8));
        check("t1_word0", first_word, 64'h0706050403020100);
        check("t1_fdone", 64'(fd_count), 64'd1);
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);
        check("t1_rearmed", 64'(debug[5:4]), 64'(ST_ARMED));

        // Short frame ended by vsync after 13 pixels: padded tail word
        wdata_ready = 1'b0;
        words_seen  = 0;
        fd_count    = 0;
        frame_start();
        pixels(13, 0, 1'b1);
        frame_end_vsync();
        idle(5);
        check("t3_armed", 64'(debug[5:4]), 64'(ST_ARMED));
        check("t3_valid", 64'(wdata_valid), 64'd1);
        check("t3_burst_armed", 64'(wdata_burst_valid), 64'd1);
        check("t3_fdone", 64'(fd_count), 64'd1);
        wdata_ready = 1'b1;
        idle(4);
        wdata_ready = 1'b0;
        check("t3_words", 64'(words_seen), 64'd2);
        check("t3_tail", last_word, 64'h0000_000c_0b0a_0908);
        check("t3_drained", 64'(wdata_burst_valid), 64'd0);

        // Burst threshold at 15/16 words in CAPTURE, push and pop in one cycle
        frame_start();
        pixels(120, 0, 1'b1);
        idle(2);
        check("t5_burst15", 64'(wdata_burst_valid), 64'd0);
        check("t5_valid15", 64'(wdata_valid), 64'd1);
        pixels(8, 120, 1'b1);
        idle(2);
        check("t5_burst16", 64'(wdata_burst_valid), 64'd1);
        pixels(7, 128, 1'b1);
        cam_href      = 1'b1;
        cam_pix_valid = 1'b1;
        cam_data      = 8'd135;
        model_byte(cam_data);
        cycle();
        cam_href      = 1'b0;
        cam_pix_valid = 1'b0;
        wdata_ready   = 1'b1;
        cycle();
        wdata_ready   = 1'b0;
        check("t5_pushpop", 64'(wdata_burst_valid), 64'd1);
        wdata_ready   = 1'b1;
        cycle();
        wdata_ready   = 1'b0;
        check("t5_after_pop", 64'(wdata_burst_valid), 64'd0);
        frame_end_vsync();
        idle(4);
        wdata_ready = 1'b1;
        idle(20);
        wdata_ready = 1'b0;
        check("t5_q_empty", 64'(exp_q.size()), 64'd0);
        check("t5_fifo_empty", 64'(wdata_valid), 64'd0);

        // STOP mid-frame: the frame completes, then capture goes idle
        wdata_ready = 1'b1;
        frame_start();
        pixels(20, 0, 1'b1);
        send_cmd(CMD_STOP);
        check("t4_still_capture", 64'(debug[5:4]), 64'(ST_CAPTURE));
        check("t4_stop_pending", 64'(debug[3]), 64'd1);
        pixels(23, 20, 1'b1);
        fd_count = 0;
        frame_end_vsync();
        idle(6);
        check("t4_fdone", 64'(fd_count), 64'd1);
        check("t4_idle", 64'(debug[5:4]), 64'(ST_IDLE));
        check("t4_stop_cleared", 64'(debug[3]), 64'd0);
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);
        cam_vsync = 1'b0;
        cycle();
        idle(2);
        check("t4_ignore_vsync", 64'(debug[5:4]), 64'(ST_IDLE));
        pixels(16, 0, 1'b0);
        idle(4);
        check("t4_no_words", 64'(wdata_valid), 64'd0);

        // Writer stalled for a whole frame: 64 words kept, then overflow
        wdata_ready = 1'b0;
        send_cmd(CMD_START);
        check("t2_armed", 64'(debug[5:4]), 64'(ST_ARMED));
        pushed     = 0;
        push_limit = 64;
        frame_start();
        pixels(512, 0, 1'b1);
        idle(3);
        check("t2_no_ovf_at_64", 64'(overflow_err), 64'd0);
        check("t2_full", 64'(debug[2]), 64'd1);
        pixels(8, 512, 1'b1);
        idle(3);
        check("t2_ovf_at_65", 64'(overflow_err), 64'd1);
        pixels(FP - 520, 520, 1'b1);
        idle(6);
        check("t2_rearmed", 64'(debug[5:4]), 64'(ST_ARMED));
        send_cmd(CMD_STOP);
        check("t2_stop_armed", 64'(debug[5:4]), 64'(ST_IDLE));
        words_seen  = 0;
        wdata_ready = 1'b1;
        idle(70);
        wdata_ready = 1'b0;
        push_limit  = 1 << 30;
        check("t2_words", 64'(words_seen), 64'd64);
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);
        check("t2_ovf_sticky", 64'(overflow_err), 64'd1);

        // Reset for one cycle in the middle of a frame
        send_cmd(CMD_START);
        frame_start();
        pixels(20, 0, 1'b1);
        check("t6_capture", 64'(debug[5:4]), 64'(ST_CAPTURE));
        rst_n = 1'b0;
        cycle();
        check_reset_outputs("t6");
        rst_n = 1'b1;
        exp_q.delete();
        m_word      = '0;
        m_idx       = 0;
        wdata_ready = 1'b1;
        idle(5);
        check("t6_empty", 64'(wdata_valid), 64'd0);
        check("t6_idle", 64'(debug[5:4]), 64'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
